// File: rtl/ram2_arbiter.sv
// -----------------------------------------------------------------------------
// ram2_arbiter
//
// Shares the single program SRAM (Ram2) between instruction fetch (IF) and
// MEM-stage loads/stores that target program space. MEM always wins. While a
// data access owns the SRAM, hold_o stalls the PC so the abandoned fetch
// address is presented again once the arbiter returns to FETCH.
//
// Ports
//   clk           system clock
//   rst           asynchronous reset, active-low
//   if_addr_i     fetch address (pc)
//   inst_o        registered instruction word
//   inst_valid_o  inst_o holds the word at the previous cycle's if_addr_i
//   hold_o        combinational PC / IF stall
//   mem_req_i     MEM access request (level, held until mem_done_o)
//   mem_we_i      1 = write, 0 = read
//   mem_addr_i    data address
//   mem_wdata_i   write data
//   mem_rdata_o   read data, valid with mem_done_o after a read
//   mem_done_o    one-cycle completion pulse
//   Ram2Addr      SRAM address
//   Ram2Data      SRAM bidirectional data bus
//   Ram2OE        SRAM output enable, active-low
//   Ram2WE        SRAM write enable, active-low
//   Ram2EN        SRAM chip enable, active-low
//
// Parameters
//   ADDR_W    SRAM address width
//   DATA_W    SRAM data width
//   WR_PULSE  cycles Ram2WE is held low per write (1..4)
// -----------------------------------------------------------------------------
module ram2_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16,
  parameter int WR_PULSE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic              hold_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_done_o,
  output logic [ADDR_W-1:0] Ram2Addr,
  inout  wire  [DATA_W-1:0] Ram2Data,
  output logic              Ram2OE,
  output logic              Ram2WE,
  output logic              Ram2EN
);

  // Counter only has to reach WR_PULSE-1; keep it at least one bit wide.
  localparam int CNT_W = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WR_PULSE - 1);

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,  // instruction fetch, arbitration point
    ST_MRD   = 3'd1,  // data read, one cycle
    ST_WSET  = 3'd2,  // write address/data setup, WE high
    ST_WPUL  = 3'd3,  // WE low for WR_PULSE cycles
    ST_WHLD  = 3'd4   // WE high again, data held on the bus
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_inst;
  logic                r_inst_valid;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_done;

  logic                w_accept;
  logic                w_bus_drive;

  // A request is ignored during the done cycle, so a level request that is
  // still high when its own completion is reported cannot restart itself.
  assign w_accept = mem_req_i & ~r_done;
  assign hold_o   = (r_state != ST_FETCH) | w_accept;

  assign inst_o       = r_inst;
  assign inst_valid_o = r_inst_valid;
  assign mem_rdata_o  = r_rdata;
  assign mem_done_o   = r_done;

  // ---------------------------------------------------------------------------
  // SRAM pin decode. Pins follow the state directly so a fetch address reaches
  // the SRAM in the same cycle and the word is captured at the next edge.
  // Reset overrides everything combinationally: pulling rst low mid-write must
  // raise WE at once, not at the next clock.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    Ram2EN      = 1'b0;
    Ram2OE      = 1'b1;
    Ram2WE      = 1'b1;
    Ram2Addr    = r_addr;
    w_bus_drive = 1'b0;

    case (r_state)
      ST_FETCH: begin
        Ram2OE   = 1'b0;
        Ram2Addr = if_addr_i;
      end
      ST_MRD: begin
        Ram2OE = 1'b0;
      end
      ST_WSET: begin
        w_bus_drive = 1'b1;
      end
      ST_WPUL: begin
        Ram2WE      = 1'b0;
        w_bus_drive = 1'b1;
      end
      ST_WHLD: begin
        w_bus_drive = 1'b1;
      end
      default: begin
        Ram2EN = 1'b1;
      end
    endcase

    if (!rst) begin
      Ram2EN      = 1'b1;
      Ram2OE      = 1'b1;
      Ram2WE      = 1'b1;
      Ram2Addr    = '0;
      w_bus_drive = 1'b0;
    end
  end

  // OE is high in every driving state, so the SRAM and this block never
  // drive the bus together.
  assign Ram2Data = w_bus_drive ? r_wdata : {DATA_W{1'bz}};

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_FETCH;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_inst       <= '0;
      r_inst_valid <= 1'b0;
      r_rdata      <= '0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          // The word is always captured; when a request steals the cycle it
          // is flagged invalid and the held PC fetches it again later.
          r_inst       <= Ram2Data;
          r_inst_valid <= ~w_accept;
          r_done       <= 1'b0;
          if (w_accept) begin
            r_addr  <= mem_addr_i;
            r_wdata <= mem_wdata_i;
            r_state <= mem_we_i ? ST_WSET : ST_MRD;
          end
        end

        ST_MRD: begin
          r_inst_valid <= 1'b0;
          r_rdata      <= Ram2Data;
          r_done       <= 1'b1;
          r_state      <= ST_FETCH;
        end

        ST_WSET: begin
          r_inst_valid <= 1'b0;
          r_cnt        <= CNT_LOAD;
          r_state      <= ST_WPUL;
        end

        ST_WPUL: begin
          // Counter is loaded with WR_PULSE-1, so WE stays low for exactly
          // WR_PULSE cycles including the one in which it reaches zero.
          r_inst_valid <= 1'b0;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state <= ST_WHLD;
          end
        end

        ST_WHLD: begin
          r_inst_valid <= 1'b0;
          r_done       <= 1'b1;
          r_state      <= ST_FETCH;
        end

        default: begin
          r_inst_valid <= 1'b0;
          r_state      <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram2_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram2_arbiter
//
// Two arbiters share stimulus: u_dut1 (WR_PULSE = 1) runs a per-cycle vector
// table covering reset, fetch, read, write, read-back and back-to-back access;
// u_dut3 (WR_PULSE = 3) is checked by hand-written sequences for the long
// write pulse and for reset asserted during the write pulse. Each arbiter has
// its own behavioural SRAM.
// -----------------------------------------------------------------------------
module tb_ram2_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [17:0] if_addr   = '0;
  logic        mem_req   = 1'b0;
  logic        mem_we    = 1'b0;
  logic [17:0] mem_addr  = '0;
  logic [15:0] mem_wdata = '0;

  logic [15:0] inst1, rdata1, inst3, rdata3;
  logic        valid1, hold1, done1, oe1, we1, en1;
  logic        valid3, hold3, done3, oe3, we3, en3;
  logic [17:0] addr1, addr3;
  wire  [15:0] bus1;
  wire  [15:0] bus3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ram2_arbiter #(.ADDR_W(18), .DATA_W(16), .WR_PULSE(1)) u_dut1 (
    .clk(clk), .rst(rst), .if_addr_i(if_addr), .inst_o(inst1),
    .inst_valid_o(valid1), .hold_o(hold1), .mem_req_i(mem_req),
    .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_rdata_o(rdata1), .mem_done_o(done1), .Ram2Addr(addr1),
    .Ram2Data(bus1), .Ram2OE(oe1), .Ram2WE(we1), .Ram2EN(en1)
  );

  ram2_arbiter #(.ADDR_W(18), .DATA_W(16), .WR_PULSE(3)) u_dut3 (
    .clk(clk), .rst(rst), .if_addr_i(if_addr), .inst_o(inst3),
    .inst_valid_o(valid3), .hold_o(hold3), .mem_req_i(mem_req),
    .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_rdata_o(rdata3), .mem_done_o(done3), .Ram2Addr(addr3),
    .Ram2Data(bus3), .Ram2OE(oe3), .Ram2WE(we3), .Ram2EN(en3)
  );

  // ---------------------------------------------------------------------------
  // Behavioural SRAMs: asynchronous read while EN/OE low and WE high; a write
  // is stored mid-cycle whenever EN and WE are both low.
  // ---------------------------------------------------------------------------
  logic [15:0] sram1 [1024];
  logic [15:0] sram3 [1024];
  logic        sram_loaded = 1'b0;

  function automatic logic [15:0] init_word(input int a);
    case (a)
      0:       return 16'h0800;
      1:       return 16'h4801;
      2:       return 16'h4902;
      3:       return 16'h0000;
      4:       return 16'h5A5A;
      5:       return 16'h1111;
      6:       return 16'h2222;
      7:       return 16'h3333;
      8:       return 16'h4444;
      9:       return 16'h5555;
      'h100:   return 16'hBEEF;
      default: return 16'h0000;
    endcase
  endfunction

  assign bus1 = (!en1 && !oe1 && we1) ? sram1[addr1[9:0]] : 16'hzzzz;
  assign bus3 = (!en3 && !oe3 && we3) ? sram3[addr3[9:0]] : 16'hzzzz;

  always @(negedge clk) begin
    if (!sram_loaded) begin
      for (int i = 0; i < 1024; i++) begin
        sram1[i] <= init_word(i);
        sram3[i] <= init_word(i);
      end
      sram_loaded <= 1'b1;
    end else begin
      if (!en1 && !we1) sram1[addr1[9:0]] <= bus1;
      if (!en3 && !we3) sram3[addr3[9:0]] <= bus3;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One row = one clock cycle of u_dut1. Pin fields are checked mid-cycle,
  // registered fields just after the closing edge.
  typedef struct {
    int pc, req, we, addr, wdata;            // inputs
    int hold, we_n, oe_n, ram_addr, bchk;    // mid-cycle expectations
    int valid, inst, done, rdata;            // post-edge expectations
  } vec_t;

  function automatic vec_t mk(input int pc, req, we, addr, wdata,
                              input int hold, we_n, oe_n, ram_addr, bchk,
                              input int valid, inst, done, rdata);
    vec_t v;
    v.pc = pc; v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
    v.hold = hold; v.we_n = we_n; v.oe_n = oe_n; v.ram_addr = ram_addr;
    v.bchk = bchk; v.valid = valid; v.inst = inst; v.done = done;
    v.rdata = rdata;
    return v;
  endfunction

  // Run one MEM access on u_dut3 from a FETCH cycle. lat counts cycles from
  // the request cycle to the cycle in which done is high (0 = never seen).
  task automatic access3(input logic we, input logic [17:0] a,
                         input logic [15:0] d, output int lat,
                         output int we_lo, output logic ok_oe,
                         output logic ok_bus);
    lat = 0; we_lo = 0; ok_oe = 1'b1; ok_bus = 1'b1;
    mem_req = 1'b1; mem_we = we; mem_addr = a; mem_wdata = d;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      #2;
      if (!we3) begin
        we_lo++;
        if (!oe3) ok_oe = 1'b0;
      end
      if (we && oe3 && bus3 !== d) ok_bus = 1'b0;
      @(posedge clk); #1;
      if (done3) lat = i;
    end
    mem_req = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t vecs [20];

  initial begin
    int   lat, we_lo, done_seen, hold_seen;
    logic ok_oe, ok_bus;

    //            pc req we addr   wdata    hold we oe addr  b  val inst    dn rdata
    vecs[0]  = mk(0, 0, 0, 0,      0,       0, 1, 0, 0,     0, 1, 'h0800, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0,      0,       0, 1, 0, 1,     0, 1, 'h4801, 0, 0);
    vecs[2]  = mk(2, 0, 0, 0,      0,       0, 1, 0, 2,     0, 1, 'h4902, 0, 0);
    vecs[3]  = mk(3, 0, 0, 0,      0,       0, 1, 0, 3,     0, 1, 'h0000, 0, 0);
    vecs[4]  = mk(4, 1, 0, 'h100,  0,       1, 1, 0, 4,     0, 0, 'h5A5A, 0, 0);
    vecs[5]  = mk(4, 1, 0, 'h100,  0,       1, 1, 0, 'h100, 0, 0, 'h5A5A, 1, 'hBEEF);
    vecs[6]  = mk(4, 1, 0, 'h100,  0,       0, 1, 0, 4,     0, 1, 'h5A5A, 0, 'hBEEF);
    vecs[7]  = mk(5, 0, 0, 0,      0,       0, 1, 0, 5,     0, 1, 'h1111, 0, 'hBEEF);
    vecs[8]  = mk(6, 1, 1, 'h200,  'h1234,  1, 1, 0, 6,     0, 0, 'h2222, 0, 'hBEEF);
    vecs[9]  = mk(6, 1, 1, 'h200,  'h1234,  1, 1, 1, 'h200, 1, 0, 'h2222, 0, 'hBEEF);
    vecs[10] = mk(6, 1, 1, 'h200,  'h1234,  1, 0, 1, 'h200, 1, 0, 'h2222, 0, 'hBEEF);
    vecs[11] = mk(6, 1, 1, 'h200,  'h1234,  1, 1, 1, 'h200, 1, 0, 'h2222, 1, 'hBEEF);
    vecs[12] = mk(6, 1, 1, 'h200,  'h1234,  0, 1, 0, 6,     0, 1, 'h2222, 0, 'hBEEF);
    vecs[13] = mk(7, 1, 0, 'h200,  0,       1, 1, 0, 7,     0, 0, 'h3333, 0, 'hBEEF);
    vecs[14] = mk(7, 1, 0, 'h200,  0,       1, 1, 0, 'h200, 0, 0, 'h3333, 1, 'h1234);
    vecs[15] = mk(7, 1, 0, 'h100,  0,       0, 1, 0, 7,     0, 1, 'h3333, 0, 'h1234);
    vecs[16] = mk(8, 1, 0, 'h100,  0,       1, 1, 0, 8,     0, 0, 'h4444, 0, 'h1234);
    vecs[17] = mk(8, 1, 0, 'h100,  0,       1, 1, 0, 'h100, 0, 0, 'h4444, 1, 'hBEEF);
    vecs[18] = mk(8, 1, 0, 'h100,  0,       0, 1, 0, 8,     0, 1, 'h4444, 0, 'hBEEF);
    vecs[19] = mk(9, 0, 0, 0,      0,       0, 1, 0, 9,     0, 1, 'h5555, 0, 'hBEEF);

    // ---- reset held for three cycles ----
    repeat (3) @(posedge clk);
    #1;
    check("rst we",    32'(we1),    1);
    check("rst oe",    32'(oe1),    1);
    check("rst en",    32'(en1),    1);
    check("rst addr",  32'(addr1),  0);
    check("rst inst",  32'(inst1),  0);
    check("rst valid", 32'(valid1), 0);
    check("rst rdata", 32'(rdata1), 0);
    check("rst done",  32'(done1),  0);
    check("rst hold",  32'(hold1),  0);
    check("rst we3",   32'(we3),    1);
    rst = 1'b1;

    // ---- vector table on u_dut1 ----
    for (int i = 0; i < 20; i++) begin
      if_addr   = 18'(vecs[i].pc);
      mem_req   = vecs[i].req[0];
      mem_we    = vecs[i].we[0];
      mem_addr  = 18'(vecs[i].addr);
      mem_wdata = 16'(vecs[i].wdata);
      #2;
      check($sformatf("row%0d hold", i),  32'(hold1), vecs[i].hold);
      check($sformatf("row%0d we", i),    32'(we1),   vecs[i].we_n);
      check($sformatf("row%0d oe", i),    32'(oe1),   vecs[i].oe_n);
      check($sformatf("row%0d en", i),    32'(en1),   0);
      check($sformatf("row%0d addr", i),  32'(addr1), vecs[i].ram_addr);
      if (vecs[i].bchk != 0)
        check($sformatf("row%0d bus", i), 32'(bus1),  vecs[i].wdata);
      @(posedge clk); #1;
      check($sformatf("row%0d valid", i), 32'(valid1), vecs[i].valid);
      check($sformatf("row%0d inst", i),  32'(inst1),  vecs[i].inst);
      check($sformatf("row%0d done", i),  32'(done1),  vecs[i].done);
      check($sformatf("row%0d rdata", i), 32'(rdata1), vecs[i].rdata);
    end

    // ---- realign both arbiters ----
    mem_req = 1'b0;
    if_addr = '0;
    rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // ---- WR_PULSE = 3 write, then read back ----
    access3(1'b1, 18'h200, 16'h1234, lat, we_lo, ok_oe, ok_bus);
    check("w3 latency",   32'(lat),    6);
    check("w3 we low",    32'(we_lo),  3);
    check("w3 oe high",   32'(ok_oe),  1);
    check("w3 bus drive", 32'(ok_bus), 1);
    access3(1'b0, 18'h200, 16'h0000, lat, we_lo, ok_oe, ok_bus);
    check("r3 latency",   32'(lat),    2);
    check("r3 rdata",     32'(rdata3), 'h1234);

    // ---- reset asserted in the middle of the write pulse ----
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h300; mem_wdata = 16'hABCD;
    @(posedge clk); #1;          // now WSET
    @(posedge clk); #1;          // now WPUL
    #1;
    check("wpul we low",  32'(we3), 0);
    rst = 1'b0;
    #1;
    check("arst we",   32'(we3),   1);
    check("arst oe",   32'(oe3),   1);
    check("arst en",   32'(en3),   1);
    check("arst addr", 32'(addr3), 0);
    check("arst done", 32'(done3), 0);
    mem_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    done_seen = 0;
    hold_seen = 0;
    for (int i = 0; i < 6; i++) begin
      #2;
      if (hold3) hold_seen = 1;
      @(posedge clk); #1;
      if (done3) done_seen = 1;
    end
    check("post rst no done", 32'(done_seen), 0);
    check("post rst no hold", 32'(hold_seen), 0);
    check("post rst valid",   32'(valid3),    1);
    check("post rst inst",    32'(inst3),     'h0800);
    check("dropped write",    32'(sram3[10'h300]), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
